// File: rtl/instr_loader.sv
// Byte-stream instruction loader: deframes SYNC/N/payload(/CHK) into 18-bit words for the ALU instruction memory.
// Optional macro INSTR_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and its accumulator.
module instr_loader #(
  parameter int          ADDR_W    = 5,
  parameter int          DEPTH     = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [17:0]       wr_data,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_B0    = 3'd2,
    S_B1    = 3'd3,
    S_B2    = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                in_ready_r, wr_en_r, core_reset_r, done_r, error_r;
  logic [ADDR_W-1:0]   wr_addr_r, idx_r;
  logic [17:0]         wr_data_r;
  logic [ADDR_W:0]     loaded_count_r, n_r;
  logic [1:0]          op_r;
  logic [7:0]          b1_r;
  logic                take_s, sync_take_s, n_bad_s, last_s, wr_fire_s;

  assign take_s      = in_valid && in_ready_r;
  assign sync_take_s = take_s && (in_data == SYNC_BYTE) &&
                       ((state_r == S_IDLE) || (state_r == S_ERROR));
  assign n_bad_s     = (in_data == 8'd0) || (int'(in_data) > DEPTH);
  assign last_s      = (({1'b0, idx_r} + {{ADDR_W{1'b0}}, 1'b1}) == n_r);
  assign wr_fire_s   = take_s && (state_r == S_B2);

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc_r;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Running XOR over N and every payload byte of the current frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_acc_r <= 8'd0;
    end else if (sync_take_s) begin
      chk_acc_r <= 8'd0;
    end else if (take_s && (state_r == S_COUNT)) begin
      chk_acc_r <= in_data;
    end else if (take_s && ((state_r == S_B0) || (state_r == S_B1) || (state_r == S_B2))) begin
      chk_acc_r <= chk_fold(chk_acc_r, in_data);
    end
  end
`endif

  // Frame sequencing; SYNC is only recognised between frames.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_ERROR: begin
        if (sync_take_s) state_nxt_s = S_COUNT;
        else             state_nxt_s = state_r;
      end
      S_COUNT: begin
        if (!take_s)      state_nxt_s = S_COUNT;
        else if (n_bad_s) state_nxt_s = S_ERROR;
        else              state_nxt_s = S_B0;
      end
      S_B0: begin
        if (!take_s)                   state_nxt_s = S_B0;
        else if (in_data[7:2] != 6'd0) state_nxt_s = S_ERROR;
        else                           state_nxt_s = S_B1;
      end
      S_B1: begin
        if (take_s) state_nxt_s = S_B2;
        else        state_nxt_s = S_B1;
      end
      S_B2: begin
        if (!take_s)     state_nxt_s = S_B2;
`ifdef INSTR_LOADER_CHECKSUM_EN
        else if (last_s) state_nxt_s = S_CHK;
`else
        else if (last_s) state_nxt_s = S_DONE;
`endif
        else             state_nxt_s = S_B0;
      end
      S_CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (!take_s)                  state_nxt_s = S_CHK;
        else if (in_data == chk_acc_r) state_nxt_s = S_DONE;
        else                          state_nxt_s = S_ERROR;
`else
        state_nxt_s = S_IDLE;
`endif
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, handshake and write-port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b1;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= 18'd0;
      idx_r      <= {ADDR_W{1'b0}};
      n_r        <= {(ADDR_W+1){1'b0}};
      op_r       <= 2'd0;
      b1_r       <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != S_DONE);
      wr_en_r    <= wr_fire_s;
      if (wr_fire_s) begin
        wr_addr_r <= idx_r;
        wr_data_r <= {op_r, b1_r, in_data};
        idx_r     <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if (take_s && (state_r == S_COUNT)) begin
        idx_r <= {ADDR_W{1'b0}};
        n_r   <= in_data[ADDR_W:0];
      end
      if (take_s && (state_r == S_B0)) op_r <= in_data[1:0];
      if (take_s && (state_r == S_B1)) b1_r <= in_data;
    end
  end

  // Status: done follows the DONE cycle, so it lands after the final write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_reset_r   <= 1'b1;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      loaded_count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      done_r <= (state_r == S_DONE);
      if (sync_take_s)                core_reset_r <= 1'b1;
      else if (state_r == S_DONE)     core_reset_r <= 1'b0;
      if (sync_take_s)                error_r <= 1'b0;
      else if (state_nxt_s == S_ERROR) error_r <= 1'b1;
      if (state_r == S_DONE)          loaded_count_r <= n_r;
    end
  end

  assign in_ready     = in_ready_r;
  assign wr_en        = wr_en_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign core_reset   = core_reset_r;
  assign done         = done_r;
  assign error        = error_r;
  assign loaded_count = loaded_count_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frames are built from instruction lists and compared to observed writes.
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready, wr_en, core_reset, done, error;
  logic [4:0]  wr_addr;
  logic [17:0] wr_data;
  logic [5:0]  loaded_count;

  int checks = 0;
  int errors = 0;

  logic [22:0] wr_log[$];
  int          done_cnt, nrdy_cnt;
  logic [7:0]  tx_q[$];
  logic [17:0] exp_q[$];

  instr_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .core_reset(core_reset),
    .done(done), .error(error), .loaded_count(loaded_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
      if (done) done_cnt++;
      if (!in_ready) nrdy_cnt++;
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    done_cnt = 0;
    nrdy_cnt = 0;
  endtask

  // Frame as the loader expects it: SYNC, N, 3 bytes per instruction, then optional XOR checksum.
  task automatic build_frame();
    logic [7:0] c, b0, b1, b2;
    c = 8'(exp_q.size());
    tx_q.push_back(8'hA5);
    tx_q.push_back(c);
    foreach (exp_q[i]) begin
      b0 = {6'd0, exp_q[i][17:16]};
      b1 = exp_q[i][15:8];
      b2 = exp_q[i][7:0];
      tx_q.push_back(b0); tx_q.push_back(b1); tx_q.push_back(b2);
      c = c ^ b0 ^ b1 ^ b2;
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    tx_q.push_back(c);
`endif
  endtask

  task automatic send_q(input int gap_max);
    for (int i = 0; i < tx_q.size(); i++) begin
      int   g, w;
      logic acc;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
      in_valid = 1'b1;
      in_data  = tx_q[i];
      w   = 0;
      acc = in_ready;
      @(negedge clk);
      while (!acc && w < 50) begin
        acc = in_ready;
        @(negedge clk);
        w++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL byte_accept_timeout: byte %0d actual not accepted, required accepted", i);
      end
    end
    in_valid = 1'b0;
    tx_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: actual %b required 1", in_ready); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset: actual %b required 1", core_reset); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: actual %b required 0", wr_en); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: actual %b required 0", error); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: actual %b required 0", done); end
    checks++; if (loaded_count !== 6'd0) begin errors++; $display("FAIL rst_loaded_count: actual %0d required 0", loaded_count); end
    checks++; if (wr_addr !== 5'd0 || wr_data !== 18'd0) begin errors++; $display("FAIL rst_wr_port: actual %h/%h required 0/0", wr_addr, wr_data); end
    reset = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic test_single();
    clear_logs();
    exp_q = '{18'h21234};
    build_frame();
    send_q(0);
    checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL single_wr_count: actual %0d required 1", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== {5'd0, 18'h21234}) begin errors++; $display("FAIL single_wr: actual %h required %h", wr_log[0], {5'd0, 18'h21234}); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: actual %0d required 1", done_cnt); end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL single_core_reset: actual %b required 0", core_reset); end
    checks++; if (loaded_count !== 6'd1) begin errors++; $display("FAIL single_loaded: actual %0d required 1", loaded_count); end
    checks++; if (nrdy_cnt != 1) begin errors++; $display("FAIL single_ready_low: actual %0d required 1", nrdy_cnt); end
    tx_q = '{8'h00, 8'h13};
    send_q(0);
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL idle_core_reset: actual %b required 0", core_reset); end
  endtask

  task automatic test_two();
    clear_logs();
    exp_q = '{18'h01122, 18'h34455};
    build_frame();
    send_q(0);
    checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL two_wr_count: actual %0d required 2", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== {5'd0, 18'h01122}) begin errors++; $display("FAIL two_wr0: actual %h required %h", wr_log[0], {5'd0, 18'h01122}); end
      checks++; if (wr_log[1] !== {5'd1, 18'h34455}) begin errors++; $display("FAIL two_wr1: actual %h required %h", wr_log[1], {5'd1, 18'h34455}); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL two_done: actual %0d required 1", done_cnt); end
    checks++; if (loaded_count !== 6'd2) begin errors++; $display("FAIL two_loaded: actual %0d required 2", loaded_count); end
  endtask

  task automatic test_bad_chk();
`ifdef INSTR_LOADER_CHECKSUM_EN
    clear_logs();
    exp_q = '{18'h21234};
    build_frame();
    tx_q[tx_q.size()-1] = tx_q[tx_q.size()-1] ^ 8'h03;
    send_q(0);
    checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL badchk_wr_count: actual %0d required 1", wr_log.size()); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL badchk_error: actual %b required 1", error); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL badchk_core_reset: actual %b required 1", core_reset); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL badchk_done: actual %0d required 0", done_cnt); end
`endif
  endtask

  task automatic test_bad_payload();
    clear_logs();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h07};
    send_q(0);
    checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL badop_wr_count: actual %0d required 1", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== {5'd0, 18'h01122}) begin errors++; $display("FAIL badop_wr: actual %h required %h", wr_log[0], {5'd0, 18'h01122}); end
    end
    checks++; if (error !== 1'b1 || core_reset !== 1'b1) begin errors++; $display("FAIL badop_status: actual err=%b cr=%b required err=1 cr=1", error, core_reset); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL badop_done: actual %0d required 0", done_cnt); end
    clear_logs();
    exp_q = '{18'h2A5C3};
    build_frame();
    send_q(0);
    checks++; if (error !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL recover: actual err=%b done=%0d required err=0 done=1", error, done_cnt); end
  endtask

  task automatic test_bad_count();
    logic [7:0] streams [3][3];
    int         lens [3];
    streams = '{'{8'hA5, 8'h00, 8'h00}, '{8'hA5, 8'h21, 8'h00}, '{8'hA5, 8'h01, 8'h04}};
    lens    = '{2, 2, 3};
    for (int s = 0; s < 3; s++) begin
      clear_logs();
      for (int k = 0; k < lens[s]; k++) tx_q.push_back(streams[s][k]);
      send_q(0);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL badn%0d_error: actual %b required 1", s, error); end
      checks++; if (wr_log.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL badn%0d_activity: actual wr=%0d done=%0d required 0/0", s, wr_log.size(), done_cnt); end
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL badn%0d_core_reset: actual %b required 1", s, core_reset); end
    end
  endtask

  task automatic test_reset_midframe();
    tx_q = '{8'hA5, 8'h01, 8'h02, 8'h12};
    send_q(0);
    test_reset();
    tx_q = '{8'h34, 8'h25};
    send_q(0);
    checks++; if (wr_log.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL midrst_activity: actual wr=%0d done=%0d required 0/0", wr_log.size(), done_cnt); end
    checks++; if (core_reset !== 1'b1 || error !== 1'b0 || loaded_count !== 6'd0) begin errors++; $display("FAIL midrst_status: actual cr=%b err=%b lc=%0d required 1/0/0", core_reset, error, loaded_count); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int n, noise;
      logic [7:0] nb;
      clear_logs();
      n = (f == 0) ? 32 : int'($urandom_range(32, 1));
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(18'($urandom));
      if (f == 0) exp_q[0][15:8] = 8'hA5;
      noise = int'($urandom_range(2, 0));
      for (int i = 0; i < noise; i++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h00;
        tx_q.push_back(nb);
      end
      build_frame();
      send_q((f % 2 == 0) ? 3 : 0);
      checks++; if (wr_log.size() != n) begin errors++; $display("FAIL rnd%0d_wr_count: actual %0d required %0d", f, wr_log.size(), n); end
      else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (wr_log[i] !== {5'(i), exp_q[i]}) begin errors++; $display("FAIL rnd%0d_wr%0d: actual %h required %h", f, i, wr_log[i], {5'(i), exp_q[i]}); end
        end
      end
      checks++; if (done_cnt != 1 || loaded_count !== 6'(n)) begin errors++; $display("FAIL rnd%0d_done: actual done=%0d lc=%0d required 1/%0d", f, done_cnt, loaded_count, n); end
      checks++; if (core_reset !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rnd%0d_status: actual cr=%b err=%b required 0/0", f, core_reset, error); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_bad_chk();
    test_bad_payload();
    test_bad_count();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
